la_wb_initiator: RTL and testbench
==================================

# la_wb_initiator

Wishbone classic single-transfer initiator for the Caravel user area. It accepts a read or write command on a valid/ready port (driven from logic-analyzer bits or a local sequencer) and runs one Wishbone B4 classic cycle against a user-area responder, such as the FPU register slave. It returns the read data and a completion status, and bounds every cycle with a timeout so a dead responder cannot hang the bench.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles with cyc/stb asserted before abort; legal range 1..65535.
- wb_clk_i  input  1  clock; all logic on the rising edge.
- wb_rst_ni  input  1  reset, asynchronous, active-low.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  high exactly when the FSM is in IDLE.
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_adr_i  input  32  byte address.
- cmd_dat_i  input  32  write data.
- cmd_sel_i  input  4  byte lane selects.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  response consumed.
- rsp_dat_o  output  32  read data; 0 for writes, errors and timeouts.
- rsp_status_o  output  2  00 = ack, 01 = bus error, 10 = timeout.
- wbm_cyc_o, wbm_stb_o  output  1 each  Wishbone cycle and strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  Wishbone byte selects.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_dat_i  input  32  responder read data.
- wbm_ack_i  input  1  responder acknowledge.
- wbm_err_i  input  1  responder error.
- busy_o  output  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready_o = 1.
  - A command handshake (cmd_valid_i & cmd_ready_o at a rising edge) latches we, adr, dat and sel into the wbm_* registers.
  - Same edge: enter BUS, set cyc = stb = 1, clear the timeout counter.
- BUS:
  - cyc, stb, we, sel, adr and dat are held stable.
  - cmd_valid_i is ignored.
  - Counter increments every cycle.
- BUS exit, evaluated at each rising edge in priority order:
  - wbm_err_i: status 01, rsp_dat 0.
  - wbm_ack_i: status 00; rsp_dat = wbm_dat_i on a read, 0 on a write.
  - Counter equals TIMEOUT_CYCLES-1 with neither ack nor err: status 10, rsp_dat 0.
  - Any exit clears cyc and stb at that same edge and enters RESP.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_status_o held stable.
  - On rsp_valid_o & rsp_ready_i: return to IDLE and clear rsp_valid_o.
- wbm_ack_i / wbm_err_i seen in IDLE or RESP (stray or late) are ignored and change no output.
- Counter width is ceil(log2(TIMEOUT_CYCLES+1)) bits. It never wraps, because exit occurs at TIMEOUT_CYCLES-1.

## Timing
- All outputs are registered except cmd_ready_o and busy_o, which are direct state decodes.
- Reset values: every wbm_* output 0, rsp_valid_o 0, rsp_dat_o 0, rsp_status_o 00, busy_o 0, cmd_ready_o 1.
- Command handshake at edge E0 puts cyc/stb high from E0.
- Ack sampled at edge E0+1+n (n wait states): cyc/stb low and rsp_valid_o high from that edge.
- A zero-wait responder gives exactly 1 cycle of cyc/stb and rsp_valid_o one cycle after the handshake.
- Timeout: cyc/stb high for exactly TIMEOUT_CYCLES cycles.
- Throughput: the next command can handshake no earlier than the edge after the RESP handshake. Minimum is 3 cycles per transfer with rsp_ready_i tied high.
- Reset asserted mid-operation (any state): all outputs return to reset values immediately and asynchronously; the in-flight cycle is dropped with no response.

## Test plan
- Zero-wait write, adr 0x3000_0004, dat 0x1234_5678, sel 0xF:
  - cyc/stb high exactly 1 cycle with those values.
  - Response status 00, dat 0, rsp_valid one cycle after the handshake.
- Read, responder acks after 3 wait states with 0xCAFE_F00D:
  - cyc/stb high 4 cycles.
  - rsp_dat_o 0xCAFE_F00D, status 00.
  - cmd_valid_i pulsed during BUS is ignored (cmd_ready_o 0).
- wbm_err_i and wbm_ack_i asserted together in BUS:
  - status 01, rsp_dat 0.
  - Extra ack pulses during RESP leave outputs unchanged.
- TIMEOUT_CYCLES = 8, responder never acks:
  - cyc/stb high exactly 8 cycles.
  - status 10, busy_o low after the response handshake.
- rsp_ready_i held low 5 cycles:
  - rsp_valid_o, rsp_dat_o and rsp_status_o remain stable.
  - cmd_ready_o stays 0 until the handshake, then reads 1 the next cycle.
- wb_rst_ni pulled low mid-BUS between clock edges:
  - cyc/stb fall before the next edge and all outputs show reset values.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/la_wb_initiator.sv
// ---------------------------------------------------------------------------
// la_wb_initiator
//
// Wishbone B4 classic single-transfer initiator. A read or write command is
// accepted on a valid/ready port, one Wishbone classic cycle is run against
// a user-area responder, and the read data plus a completion status are
// returned on a valid/ready response port. Every bus cycle is bounded by a
// timeout so a dead responder cannot hang the caller.
//
// Parameters
//   TIMEOUT_CYCLES  maximum cycles with cyc/stb high before abort (1..65535)
//
// Ports
//   wb_clk_i        clock, rising edge
//   wb_rst_ni       asynchronous active-low reset
//   cmd_valid_i     command present
//   cmd_ready_o     command accepted this edge (high only in IDLE)
//   cmd_we_i        1 = write, 0 = read
//   cmd_adr_i       byte address
//   cmd_dat_i       write data
//   cmd_sel_i       byte lane selects
//   rsp_valid_o     response available
//   rsp_ready_i     response consumed
//   rsp_dat_o       read data (0 for writes, errors and timeouts)
//   rsp_status_o    00 = ack, 01 = bus error, 10 = timeout
//   wbm_*           Wishbone initiator signals
//   busy_o          high whenever a transfer is in flight (not IDLE)
// ---------------------------------------------------------------------------
module la_wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] STATUS_ACK     = 2'b00;
    localparam logic [1:0] STATUS_ERR     = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;

    // The counter starts at 0 on the handshake edge, so reaching
    // TIMEOUT_CYCLES-1 on a BUS edge means cyc/stb have been high for
    // exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (timeout_cnt == CNT_LAST);

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. Ack/err only matter in BUS; in IDLE and RESP they
    // are treated as stray and ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid_i) next_state = BUS;
            BUS:     if (wbm_err_i || wbm_ack_i || timeout_hit) next_state = RESP;
            RESP:    if (rsp_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered bus and response outputs. Command fields are captured on
    // the handshake and held through BUS; the response is built on the BUS
    // exit edge with error taking priority over ack, and ack over timeout.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            wbm_sel_o    <= '0;
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= STATUS_ACK;
            timeout_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= cmd_we_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        timeout_cnt <= '0;
                    end
                end
                BUS: begin
                    if (wbm_err_i) begin
                        wbm_cyc_o    <= 1'b0;
                        wbm_stb_o    <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        rsp_dat_o    <= '0;
                        rsp_status_o <= STATUS_ERR;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o    <= 1'b0;
                        wbm_stb_o    <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        rsp_dat_o    <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        rsp_status_o <= STATUS_ACK;
                    end else if (timeout_hit) begin
                        wbm_cyc_o    <= 1'b0;
                        wbm_stb_o    <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        rsp_dat_o    <= '0;
                        rsp_status_o <= STATUS_TIMEOUT;
                    end else begin
                        timeout_cnt  <= timeout_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_la_wb_initiator
//
// Directed self-checking bench for la_wb_initiator with TIMEOUT_CYCLES = 8.
// Inputs are driven 1 ns after a rising edge; outputs are read at that same
// point, away from the active edge. A negedge counter tracks how many cycles
// cyc is high per transfer.
// ---------------------------------------------------------------------------
module tb_la_wb_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack;
    logic        wbm_err;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;
    int cycCount   = 0;

    la_wb_initiator #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_status_o(rsp_status),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack),
        .wbm_err_i   (wbm_err),
        .busy_o      (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with cyc high, sampled mid-cycle.
    always @(negedge clk) begin
        if (wbm_cyc) cycCount++;
    end

    // Hard stop in case something goes badly wrong.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cyc"},       32'(wbm_cyc),    0);
        checkOutput({tag, "_stb"},       32'(wbm_stb),    0);
        checkOutput({tag, "_we"},        32'(wbm_we),     0);
        checkOutput({tag, "_sel"},       32'(wbm_sel),    0);
        checkOutput({tag, "_adr"},       wbm_adr,         0);
        checkOutput({tag, "_datOut"},    wbm_dat_o,       0);
        checkOutput({tag, "_rspValid"},  32'(rsp_valid),  0);
        checkOutput({tag, "_rspDat"},    rsp_dat,         0);
        checkOutput({tag, "_rspStatus"}, 32'(rsp_status), 0);
        checkOutput({tag, "_busy"},      32'(busy),       0);
        checkOutput({tag, "_cmdReady"},  32'(cmd_ready),  1);
    endtask

    // Present one command from IDLE; returns 1 ns after the handshake edge.
    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for rsp_valid.
    task automatic waitResponse(input string tag, input int bound);
        int n = 0;
        while (!rsp_valid && n < bound) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_rspArrived"}, 32'(rsp_valid), 1);
    endtask

    task automatic consumeResponse();
        rsp_ready = 1'b1;
        stepCycle();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack   = 1'b0;
        wbm_err   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        stepCycle();

        // Zero-wait write.
        $display("[TB] zero-wait write");
        wbm_dat_i = 32'hDEAD_BEEF;
        cycCount  = 0;
        checkOutput("wr_cmdReadyIdle", 32'(cmd_ready), 1);
        applyStimulus(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF);
        checkOutput("wr_cyc",       32'(wbm_cyc),   1);
        checkOutput("wr_stb",       32'(wbm_stb),   1);
        checkOutput("wr_we",        32'(wbm_we),    1);
        checkOutput("wr_adr",       wbm_adr,        32'h3000_0004);
        checkOutput("wr_dat",       wbm_dat_o,      32'h1234_5678);
        checkOutput("wr_sel",       32'(wbm_sel),   32'hF);
        checkOutput("wr_busy",      32'(busy),      1);
        checkOutput("wr_cmdReady",  32'(cmd_ready), 0);
        checkOutput("wr_rspEarly",  32'(rsp_valid), 0);
        wbm_ack = 1'b1;
        stepCycle();
        wbm_ack = 1'b0;
        checkOutput("wr_cycLow",    32'(wbm_cyc),    0);
        checkOutput("wr_stbLow",    32'(wbm_stb),    0);
        checkOutput("wr_rspValid",  32'(rsp_valid),  1);
        checkOutput("wr_status",    32'(rsp_status), 0);
        checkOutput("wr_rspDat",    rsp_dat,         0);
        checkOutput("wr_cycCycles", cycCount,        1);
        consumeResponse();
        checkOutput("wr_rspCleared", 32'(rsp_valid), 0);
        checkOutput("wr_cmdReady2",  32'(cmd_ready), 1);
        checkOutput("wr_busyLow",    32'(busy),      0);

        // Read with 3 wait states; a command pulse during BUS is ignored.
        $display("[TB] read with 3 wait states");
        cycCount  = 0;
        wbm_dat_i = 32'h0;
        applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h9999_9999;
        checkOutput("rd_cmdReadyBus", 32'(cmd_ready), 0);
        stepCycle();
        cmd_valid = 1'b0;
        checkOutput("rd_adrHeld", wbm_adr,      32'h3000_0010);
        checkOutput("rd_weHeld",  32'(wbm_we),  0);
        stepCycle();
        stepCycle();
        checkOutput("rd_cycWait", 32'(wbm_cyc), 1);
        wbm_dat_i = 32'hCAFE_F00D;
        wbm_ack   = 1'b1;
        stepCycle();
        wbm_ack   = 1'b0;
        wbm_dat_i = 32'h0;
        checkOutput("rd_rspValid",  32'(rsp_valid),  1);
        checkOutput("rd_rspDat",    rsp_dat,         32'hCAFE_F00D);
        checkOutput("rd_status",    32'(rsp_status), 0);
        checkOutput("rd_cycCycles", cycCount,        4);
        consumeResponse();
        stepCycle();
        checkOutput("rd_noGhostCmd", 32'(wbm_cyc),   0);
        checkOutput("rd_cmdReady",   32'(cmd_ready), 1);

        // Error and ack together; stray acks in RESP change nothing.
        $display("[TB] error with simultaneous ack");
        applyStimulus(1'b0, 32'h3000_0020, 32'h0, 4'h3);
        wbm_dat_i = 32'h1111_2222;
        wbm_ack   = 1'b1;
        wbm_err   = 1'b1;
        stepCycle();
        wbm_ack   = 1'b0;
        wbm_err   = 1'b0;
        checkOutput("err_rspValid", 32'(rsp_valid),  1);
        checkOutput("err_status",   32'(rsp_status), 1);
        checkOutput("err_rspDat",   rsp_dat,         0);
        for (int i = 0; i < 3; i++) begin
            wbm_ack   = 1'b1;
            wbm_dat_i = 32'h5555_0000 + 32'(i);
            stepCycle();
            checkOutput("errStray_rspValid", 32'(rsp_valid),  1);
            checkOutput("errStray_status",   32'(rsp_status), 1);
            checkOutput("errStray_rspDat",   rsp_dat,         0);
            checkOutput("errStray_cyc",      32'(wbm_cyc),    0);
        end
        wbm_ack = 1'b0;
        consumeResponse();
        checkOutput("err_busyLow", 32'(busy), 0);

        // Timeout with a silent responder, then a slow response consumer.
        $display("[TB] timeout and response backpressure");
        cycCount = 0;
        applyStimulus(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        waitResponse("to", 40);
        checkOutput("to_cycCycles", cycCount,        8);
        checkOutput("to_status",    32'(rsp_status), 2);
        checkOutput("to_rspDat",    rsp_dat,         0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("hold_rspValid", 32'(rsp_valid),  1);
            checkOutput("hold_status",   32'(rsp_status), 2);
            checkOutput("hold_rspDat",   rsp_dat,         0);
            checkOutput("hold_cmdReady", 32'(cmd_ready),  0);
        end
        consumeResponse();
        checkOutput("to_cmdReady", 32'(cmd_ready), 1);
        checkOutput("to_busyLow",  32'(busy),      0);
        checkOutput("to_rspClear", 32'(rsp_valid), 0);

        // Asynchronous reset in the middle of BUS.
        $display("[TB] reset mid-BUS");
        applyStimulus(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        stepCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midReset");
        #3;
        rst_n = 1'b1;
        stepCycle();
        checkOutput("postReset_rspValid", 32'(rsp_valid), 0);
        checkOutput("postReset_cmdReady", 32'(cmd_ready), 1);
        applyStimulus(1'b0, 32'h3000_0044, 32'h0, 4'hF);
        checkOutput("postReset_adr", wbm_adr, 32'h3000_0044);
        stepCycle();
        wbm_dat_i = 32'h0BAD_F00D;
        wbm_ack   = 1'b1;
        stepCycle();
        wbm_ack   = 1'b0;
        checkOutput("postReset_rspValid2", 32'(rsp_valid),  1);
        checkOutput("postReset_rspDat",    rsp_dat,         32'h0BAD_F00D);
        checkOutput("postReset_status",    32'(rsp_status), 0);
        consumeResponse();
        checkOutput("postReset_busyLow",   32'(busy),       0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
